// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the line-granular UART transmit arbiter.
package uart_arb_pkg;

  typedef logic [7:0] uart_byte_t;

  typedef enum logic [1:0] {
    IDLE,
    TAG,
    STREAM
  } state_t;

  localparam uart_byte_t NEWLINE  = 8'h0A;
  localparam uart_byte_t TAG_BASE = 8'h30;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and UART-side handshake bundle for uart_tx_arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned N_REQ = 2
);
  import uart_arb_pkg::*;

  localparam int unsigned IDW = id_width(N_REQ);

  logic [N_REQ-1:0]   in_valid;
  logic [N_REQ-1:0]   in_ready;
  logic [8*N_REQ-1:0] in_bits;
  logic               out_valid;
  logic               out_ready;
  uart_byte_t         out_bits;
  logic               grant_valid;
  logic [IDW-1:0]     grant_id;

  modport master (
    output in_valid, in_bits, out_ready,
    input  in_ready, out_valid, out_bits, grant_valid, grant_id
  );

  modport slave (
    input  in_valid, in_bits, out_ready,
    output in_ready, out_valid, out_bits, grant_valid, grant_id
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin priority select: first asserted request at or after ptr, wrapping.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDW   = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic [IDW-1:0]   idx,
  output logic             found
);

  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                              input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return IDW'(s);
  endfunction

  // Scan from the farthest offset down so the nearest request wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (req[wrap_idx(ptr, N_REQ - 1 - k)]) begin
        idx   = wrap_idx(ptr, N_REQ - 1 - k);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, line-granular arbiter sharing one UART byte stream among N_REQ
// requesters, with an optional ASCII source tag at the start of each grant.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned N_REQ        = 2,
  parameter int unsigned MAX_BURST    = 128,
  parameter int unsigned IDLE_TIMEOUT = 64,
  parameter int unsigned TAG_EN       = 1
) (
  input logic             clock,
  input logic             reset,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned IDW = id_width(N_REQ);
  localparam int unsigned BW  = $clog2(MAX_BURST + 1);
  localparam int unsigned TW  = (IDLE_TIMEOUT == 0) ? 1 : $clog2(IDLE_TIMEOUT + 1);

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] gid_q, gid_d;
  logic [BW-1:0]  burst_q, burst_d;
  logic [TW-1:0]  idle_q, idle_d;

  uart_byte_t [N_REQ-1:0] bytes;
  logic [IDW-1:0]         pick_idx;
  logic                   pick_found;
  logic                   sel_valid;
  uart_byte_t             sel_byte;
  logic                   beat;
  logic                   last_beat;
  logic                   timeout;
  logic [IDW-1:0]         next_ptr;

  logic             out_valid_c;
  uart_byte_t       out_bits_c;
  logic [N_REQ-1:0] in_ready_c;

  assign bytes = bus.in_bits;

  rr_pick #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_pick (
    .req   (bus.in_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign sel_valid = bus.in_valid[gid_q];
  assign sel_byte  = bytes[gid_q];
  assign beat      = sel_valid && bus.out_ready;
  assign last_beat = beat && ((sel_byte == NEWLINE) || (32'(burst_q) + 1 == MAX_BURST));
  assign timeout   = !sel_valid && (IDLE_TIMEOUT != 0) && (32'(idle_q) + 1 == IDLE_TIMEOUT);
  assign next_ptr  = (32'(gid_q) + 1 == N_REQ) ? '0 : gid_q + IDW'(1);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gid_q    <= '0;
      burst_q  <= '0;
      idle_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gid_q    <= gid_d;
      burst_q  <= burst_d;
      idle_q   <= idle_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gid_d       = gid_q;
    burst_d     = burst_q;
    idle_d      = idle_q;
    out_valid_c = 1'b0;
    out_bits_c  = '0;
    in_ready_c  = '0;
    unique case (state_q)
      IDLE: begin
        burst_d = '0;
        idle_d  = '0;
        if (pick_found) begin
          gid_d   = pick_idx;
          state_d = (TAG_EN != 0) ? TAG : STREAM;
        end
      end
      TAG: begin
        out_valid_c = 1'b1;
        out_bits_c  = TAG_BASE + 8'(gid_q);
        if (bus.out_ready) state_d = STREAM;
      end
      STREAM: begin
        out_valid_c       = sel_valid;
        out_bits_c        = sel_byte;
        in_ready_c[gid_q] = bus.out_ready;
        if (beat) begin
          burst_d = burst_q + BW'(1);
          idle_d  = '0;
        end else if (!sel_valid && (idle_q != '1)) begin
          idle_d = idle_q + TW'(1);
        end
        // Newline, burst limit and timeout all collapse into one release.
        if (last_beat || timeout) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced quiet for as long as reset is held.
  assign bus.out_valid   = reset && out_valid_c;
  assign bus.out_bits    = reset ? out_bits_c : '0;
  assign bus.in_ready    = reset ? in_ready_c : '0;
  assign bus.grant_valid = reset && (state_q != IDLE);
  assign bus.grant_id    = gid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: cycle table, directed corner cases,
// and randomized line traffic checked against a grant-level reference model.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int unsigned N  = 3;
  localparam int unsigned MB = 4;
  localparam int unsigned TO = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  uart_tx_arbiter_if #(.N_REQ(N)) bus();

  uart_tx_arbiter #(
    .N_REQ        (N),
    .MAX_BURST    (MB),
    .IDLE_TIMEOUT (TO),
    .TAG_EN       (1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  uart_byte_t src_q[N][$];
  uart_byte_t out_log[$];
  uart_byte_t exp_q[$];
  int         gaps[$];
  int         low_run;
  logic       prev_gv;
  bit         model_on;
  int         m_ptr;
  int         holder;

  logic       s_gv, s_ov;
  logic [1:0] s_gid;
  uart_byte_t s_ob;
  logic [N-1:0] s_ir;

  typedef struct {
    logic [2:0] iv;
    uart_byte_t b0;
    uart_byte_t b1;
    logic       rdy;
    logic       ov;
    uart_byte_t ob;
    logic [2:0] ir;
    logic       gv;
    logic [1:0] gid;
  } vec_t;

  vec_t tbl[18];

  function automatic vec_t mk(input logic [2:0] iv, input uart_byte_t b0, input uart_byte_t b1,
                              input logic rdy, input logic ov, input uart_byte_t ob,
                              input logic [2:0] ir, input logic gv, input logic [1:0] gid);
    vec_t v;
    v.iv = iv; v.b0 = b0; v.b1 = b1; v.rdy = rdy;
    v.ov = ov; v.ob = ob; v.ir = ir; v.gv = gv; v.gid = gid;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic load(input int i, input string s);
    for (int k = 0; k < s.len(); k++) src_q[i].push_back(8'(s[k]));
  endtask

  // Grant-level model: who should win, and which bytes the grant must carry.
  task automatic model_check(input bit rdy);
    logic [N-1:0] allowed;
    if (s_gv && !prev_gv) begin
      int pick;
      pick = -1;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (pick < 0 && src_q[j].size() > 0) pick = j;
      end
      chk("rnd_grant_id", 32'(s_gid), 32'(pick));
      exp_q.delete();
      if (pick >= 0) begin
        holder = pick;
        exp_q.push_back(TAG_BASE + 8'(pick));
        for (int n = 0; n < src_q[pick].size() && n < MB; n++) begin
          exp_q.push_back(src_q[pick][n]);
          if (src_q[pick][n] == NEWLINE) break;
        end
        m_ptr = (pick + 1) % N;
      end
    end
    if (s_gv) chk("rnd_hold_id", 32'(s_gid), 32'(holder));
    allowed = s_gv ? N'(1 << holder) : '0;
    chk("rnd_in_ready_mask", 32'(s_ir & ~allowed), 32'(0));
    if (s_ov && rdy) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rnd_extra_byte: got 0x%0h, want no byte", s_ob);
      end else begin
        chk("rnd_byte", 32'(s_ob), 32'(exp_q.pop_front()));
      end
    end
    if (!s_gv && prev_gv) chk("rnd_grant_complete", 32'(exp_q.size()), 32'(0));
  endtask

  // One clock: drive requesters from their queues, sample mid-cycle, retire accepted bytes.
  task automatic step(input bit rdy);
    logic [8*N-1:0] bits_v;
    logic [N-1:0]   v;
    bits_v = '0;
    v      = '0;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        v[i] = 1'b1;
        bits_v[8*i +: 8] = src_q[i][0];
      end
    end
    bus.in_valid  = v;
    bus.in_bits   = bits_v;
    bus.out_ready = rdy;
    @(negedge clock);
    s_gv  = bus.grant_valid;
    s_gid = bus.grant_id;
    s_ov  = bus.out_valid;
    s_ob  = bus.out_bits;
    s_ir  = bus.in_ready;
    if (model_on) model_check(rdy);
    if (s_ov && rdy) out_log.push_back(s_ob);
    for (int i = 0; i < N; i++) if (v[i] && s_ir[i]) void'(src_q[i].pop_front());
    if (s_gv && !prev_gv) begin
      gaps.push_back(low_run);
      low_run = 0;
    end else if (!s_gv) begin
      low_run++;
    end
    prev_gv = s_gv;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    model_on = 1'b0;
    for (int i = 0; i < N; i++) src_q[i].delete();
    reset = 1'b0;
    step(1'b1);
    step(1'b1);
    reset = 1'b1;
    out_log.delete();
    exp_q.delete();
    gaps.delete();
    low_run = 0;
    prev_gv = 1'b0;
    m_ptr   = 0;
    holder  = 0;
  endtask

  task automatic drain(input string name, input int max_cyc, input bit rnd);
    bit done;
    done = 1'b0;
    for (int n = 0; n < max_cyc && !done; n++) begin
      step(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      if (!s_gv && all_empty()) done = 1'b1;
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL %s_drain: still busy after %0d cycles, want idle", name, max_cyc);
    end
  endtask

  task automatic expect_log(input string name, input string s);
    chk({name, "_len"}, 32'(out_log.size()), 32'(s.len()));
    for (int k = 0; k < s.len() && k < out_log.size(); k++)
      chk({name, "_byte"}, 32'(out_log[k]), 32'(s[k]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, want finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = '0;
    bus.in_bits   = '0;
    bus.out_ready = 1'b0;
    model_on = 1'b0;
    prev_gv  = 1'b0;
    low_run  = 0;
    m_ptr    = 0;
    holder   = 0;

    // Reset holds every output quiet even with all requesters valid.
    load(0, "a"); load(1, "b"); load(2, "c");
    step(1'b1);
    chk("rst_out_valid", 32'(s_ov), 32'(0));
    chk("rst_in_ready", 32'(s_ir), 32'(0));
    chk("rst_grant_valid", 32'(s_gv), 32'(0));
    chk("rst_out_bits", 32'(s_ob), 32'(0));
    step(1'b1);
    chk("rst_grant_id", 32'(s_gid), 32'(0));

    // Cycle table: "hi\n" from req0, then req1 under backpressure, then wrap to req0.
    tbl[0]  = mk(3'b001, "h", 8'h00, 1, 0, 8'h00, 3'b000, 0, 0);
    tbl[1]  = mk(3'b001, "h", 8'h00, 1, 1, "0",   3'b000, 1, 0);
    tbl[2]  = mk(3'b001, "h", 8'h00, 1, 1, "h",   3'b001, 1, 0);
    tbl[3]  = mk(3'b001, "i", 8'h00, 1, 1, "i",   3'b001, 1, 0);
    tbl[4]  = mk(3'b001, 8'h0A, 8'h00, 1, 1, 8'h0A, 3'b001, 1, 0);
    tbl[5]  = mk(3'b000, 8'h00, 8'h00, 1, 0, 8'h00, 3'b000, 0, 0);
    tbl[6]  = mk(3'b011, "q", "z", 1, 0, 8'h00, 3'b000, 0, 0);
    tbl[7]  = mk(3'b011, "q", "z", 0, 1, "1", 3'b000, 1, 1);
    tbl[8]  = mk(3'b011, "q", "z", 0, 1, "1", 3'b000, 1, 1);
    tbl[9]  = mk(3'b011, "q", "z", 0, 1, "1", 3'b000, 1, 1);
    tbl[10] = mk(3'b011, "q", "z", 1, 1, "1", 3'b000, 1, 1);
    tbl[11] = mk(3'b011, "q", "z", 0, 1, "z", 3'b000, 1, 1);
    tbl[12] = mk(3'b011, "q", "z", 0, 1, "z", 3'b000, 1, 1);
    tbl[13] = mk(3'b011, "q", "z", 1, 1, "z", 3'b010, 1, 1);
    tbl[14] = mk(3'b011, "q", 8'h0A, 1, 1, 8'h0A, 3'b010, 1, 1);
    tbl[15] = mk(3'b001, "q", 8'h00, 1, 0, 8'h00, 3'b000, 0, 0);
    tbl[16] = mk(3'b001, "q", 8'h00, 1, 1, "0", 3'b000, 1, 0);
    tbl[17] = mk(3'b001, "q", 8'h00, 1, 1, "q", 3'b001, 1, 0);

    do_reset();
    for (int r = 0; r < 18; r++) begin
      bus.in_valid  = tbl[r].iv;
      bus.in_bits   = {8'h00, tbl[r].b1, tbl[r].b0};
      bus.out_ready = tbl[r].rdy;
      @(negedge clock);
      chk($sformatf("tbl%0d_out_valid", r), 32'(bus.out_valid), 32'(tbl[r].ov));
      chk($sformatf("tbl%0d_in_ready", r), 32'(bus.in_ready), 32'(tbl[r].ir));
      chk($sformatf("tbl%0d_grant_valid", r), 32'(bus.grant_valid), 32'(tbl[r].gv));
      if (tbl[r].ov) chk($sformatf("tbl%0d_out_bits", r), 32'(bus.out_bits), 32'(tbl[r].ob));
      if (tbl[r].gv) chk($sformatf("tbl%0d_grant_id", r), 32'(bus.grant_id), 32'(tbl[r].gid));
      @(posedge clock);
      #1;
    end

    // Contention: whole lines alternate between req0 and req1.
    do_reset();
    model_on = 1'b1;
    load(0, "ab\nab\n");
    load(1, "cd\ncd\n");
    drain("contention", 200, 1'b0);
    expect_log("contention", "0ab\n1cd\n0ab\n1cd\n");

    // Burst limit: 10 plain bytes split into 4,4,2 with one idle cycle before each grant.
    do_reset();
    model_on = 1'b1;
    load(1, "ABCDEFGHIJ");
    drain("burst", 200, 1'b0);
    expect_log("burst", "1ABCD1EFGH1IJ");
    chk("burst_grants", 32'(gaps.size()), 32'(3));
    foreach (gaps[k]) chk("burst_gap", 32'(gaps[k]), 32'(1));

    // Backpressure on tag and data, then idle timeout counted from the last beat.
    do_reset();
    load(0, "x");
    load(1, "y\n");
    step(1'b1);
    chk("bp_arb_grant_valid", 32'(s_gv), 32'(0));
    repeat (7) begin
      step(1'b0);
      chk("bp_tag_valid", 32'(s_ov), 32'(1));
      chk("bp_tag_bits", 32'(s_ob), 32'("0"));
      chk("bp_tag_in_ready", 32'(s_ir), 32'(0));
    end
    step(1'b1);
    chk("bp_tag_accept", 32'(s_ob), 32'("0"));
    repeat (7) begin
      step(1'b0);
      chk("bp_data_valid", 32'(s_ov), 32'(1));
      chk("bp_data_bits", 32'(s_ob), 32'("x"));
      chk("bp_data_in_ready", 32'(s_ir), 32'(0));
    end
    step(1'b1);
    chk("bp_beat_bits", 32'(s_ob), 32'("x"));
    chk("bp_beat_in_ready", 32'(s_ir), 32'(1));
    begin
      int held;
      held = 0;
      for (int k = 0; k < 20; k++) begin
        step(1'b1);
        if (s_gv && s_gid == 2'd0) held++;
        else break;
      end
      chk("timeout_hold_cycles", 32'(held), 32'(TO));
    end
    step(1'b1);
    chk("timeout_next_gv", 32'(s_gv), 32'(1));
    chk("timeout_next_id", 32'(s_gid), 32'(1));
    chk("timeout_next_tag", 32'(s_ob), 32'("1"));
    drain("timeout", 100, 1'b0);
    expect_log("timeout", "0x1y\n");

    // Reset mid-grant drops the grant and restarts arbitration from requester 0.
    do_reset();
    load(1, "pqrs");
    for (int k = 0; k < 20 && out_log.size() < 3; k++) step(1'b1);
    chk("midrst_progress", 32'(out_log.size()), 32'(3));
    load(0, "k\n");
    reset = 1'b0;
    step(1'b1);
    chk("midrst_out_valid", 32'(s_ov), 32'(0));
    chk("midrst_in_ready", 32'(s_ir), 32'(0));
    chk("midrst_grant_valid", 32'(s_gv), 32'(0));
    reset = 1'b1;
    step(1'b1);
    chk("midrst_idle_gv", 32'(s_gv), 32'(0));
    step(1'b1);
    chk("midrst_regrant_gv", 32'(s_gv), 32'(1));
    chk("midrst_regrant_id", 32'(s_gid), 32'(0));
    chk("midrst_regrant_tag", 32'(s_ob), 32'("0"));
    chk("midrst_req1_left", 32'(src_q[1].size()), 32'(2));

    // Randomized lines with random UART backpressure against the grant model.
    for (int round = 0; round < 4; round++) begin
      do_reset();
      model_on = 1'b1;
      for (int i = 0; i < N; i++) begin
        int len;
        len = $urandom_range(0, 12);
        for (int b = 0; b < len; b++) begin
          if ($urandom_range(0, 3) == 0) src_q[i].push_back(NEWLINE);
          else src_q[i].push_back(8'("a") + 8'($urandom_range(0, 25)));
        end
      end
      drain("random", 3000, 1'b1);
    end
    model_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one simulated-UART transmit byte stream among N requesters (e.g. several harts' console writers) ahead of the SimUART serial_out port.
- Arbitration is round-robin, line-granular: a grant is held until a newline, a burst limit or an idle timeout, so lines from different sources never interleave.
- Optionally prefixes each grant with an ASCII tag byte that identifies the source.

Parameters:
- N_REQ, 2, number of requesters (2..10).
- MAX_BURST, 128, max data bytes per grant (>=1).
- IDLE_TIMEOUT, 64, cycles the holder may leave in_valid low before its grant is revoked; 0 disables the timeout.
- TAG_EN, 1, when 1 emit tag byte 8'h30+grant_id at the start of each grant.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-low reset (asserted when 0)
- in_valid  in  N_REQ  per-requester byte valid
- in_ready  out  N_REQ  per-requester byte accepted
- in_bits  in  8*N_REQ  requester i byte at [8i+7:8i]
- out_valid  out  1  byte to UART valid
- out_ready  in  1  UART accepts byte
- out_bits  out  8  byte to UART
- grant_valid  out  1  a requester holds the grant (TAG or STREAM)
- grant_id  out  IDW  current holder, IDW = max(1, clog2(N_REQ))

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0, idle_cnt=0. While in reset: out_valid=0, in_ready=all 0, grant_valid=0, out_bits=0.
- States: IDLE, TAG, STREAM.
- IDLE:
  - out_valid=0, in_ready=0.
  - If any in_valid, select the first asserted index at or after rr_ptr (wrapping) and latch it to grant_id.
  - Next state is TAG if TAG_EN, else STREAM. burst_cnt and idle_cnt are cleared.
  - Arbitration costs exactly 1 cycle.
- TAG:
  - out_valid=1, out_bits=8'h30+grant_id, in_ready=0.
  - On out_valid&out_ready, go to STREAM.
  - The tag byte is not counted in burst_cnt and is not subject to the timeout.
- STREAM: combinational pass-through, zero latency.
  - out_valid=in_valid[g], out_bits=in_bits[g], in_ready[g]=out_ready; other in_ready=0.
  - On beat (in_valid[g]&out_ready): burst_cnt+1 and idle_cnt cleared.
  - Release on the beat if bits==8'h0A or burst_cnt+1==MAX_BURST.
  - When in_valid[g]==0: idle_cnt+1. If IDLE_TIMEOUT!=0 and idle_cnt+1==IDLE_TIMEOUT, release.
  - Release: next state IDLE, rr_ptr=(g+1) mod N_REQ (wrap explicit, N_REQ not necessarily a power of two).
- Simultaneous newline and burst limit on one beat: single release.
- A beat in the timeout cycle is impossible, since the timeout requires in_valid[g]==0.
- After release, the next grant starts no earlier than the following cycle, because IDLE is always visited.
- grant_valid=1 in TAG and STREAM; grant_id is held stable for the whole grant.
- Counter widths: burst_cnt is clog2(MAX_BURST+1) bits; idle_cnt is clog2(IDLE_TIMEOUT+1) bits (min 1). Neither counter wraps; both clear on entry to IDLE.
- Reset mid-grant: everything returns to reset values immediately. Any byte in flight is dropped; no tag or partial state survives.
- Requesters are required to hold in_valid/in_bits until accepted. The arbiter does not check this.

Decomposition:
- Shared package uart_arb_pkg:
  - typedef uart_byte_t (8 bits).
  - state enum {IDLE, TAG, STREAM}.
  - constants NEWLINE=8'h0A, TAG_BASE=8'h30.
- One sub-module, rr_pick, is natural: combinational round-robin priority select (N_REQ request vector + pointer -> index + found).

Test Plan:
- Single source: req0 sends "hi\n" with out_ready=1, TAG_EN=1 -> out stream '0','h','i',8'h0A; grant_valid falls the cycle after 8'h0A; rr_ptr=1.
- Contention: req0 and req1 both valid continuously, each line 2 chars + '\n' -> output alternates "0ab\n1cd\n0ab\n..."; no interleaving within a line.
- Burst limit: MAX_BURST=4, req1 sends 10 non-newline bytes -> '1' + 4 bytes, release; req1 regranted after 1 IDLE cycle, since it is the only requester.
- Timeout: IDLE_TIMEOUT=5, req0 sends 'x' then drops valid -> grant released exactly 5 cycles after the 'x' beat; req1 pending is granted next.
- Backpressure: out_ready=0 for 7 cycles during TAG and STREAM -> out_valid/out_bits stable, in_ready=0 and no beats counted; idle_cnt stays 0 while in_valid held.
- Reset mid-grant: reset=0 in STREAM after 2 bytes -> next cycle out_valid=0, in_ready=0, grant_valid=0. After release, arbitration restarts from rr_ptr=0.
